bcd_val: RTL and testbench
==========================

Name: bcd_val

Overview:
- Sequential packed-BCD to binary converter, the inverse of the binary-to-BCD converter in the calculator datapath.
- Converts DIGITS BCD digits, entered on the switches/keypad path, into an unsigned binary operand for the Calculator core.
- Uses reverse double-dabble: shift right one bit per clock, then subtract 3 from every BCD digit that is >= 8.
- Has a start/rdy handshake; flags invalid digits (>9) instead of converting them.

Parameters:
- DIGITS, 4, number of packed BCD digits on bcd_in.
- BIN_W, 14, binary result width and shift-iteration count. Must satisfy 2^BIN_W >= 10^DIGITS; elaboration fails otherwise.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD, most significant digit in the top nibble.
- bin_out  output  BIN_W  converted value; held until the next accepted start.
- rdy  output  1  one-cycle pulse: bin_out/err are valid.
- busy  output  1  high while converting.
- err  output  1  last accepted request contained a digit >9; held until the next accepted start.

Behaviour:
- Reset (async, any state, including mid-conversion): state=IDLE, bin_out=0, rdy=0, busy=0, err=0, shift register=0, iteration counter=0. Any conversion in progress is abandoned with no rdy.
- States: IDLE, SHIFT.
- IDLE, start=1 at edge E (accepted start), all digits <=9:
  - Load the work register {bcd_part[4*DIGITS], bin_part[BIN_W]} = {bcd_in, 0}.
  - Clear err and counter; go to SHIFT; busy=1 after E.
- IDLE, start=1 at edge E, any digit >9:
  - Stay in IDLE; after E: err=1, bin_out=0, rdy=1 for exactly one cycle.
  - Latency 1 edge.
- SHIFT, each edge:
  - Shift the whole work register right 1 bit; the bcd_part LSB enters the bin_part MSB.
  - Then, per digit of the shifted bcd_part: if digit >= 8, digit -= 3.
  - Counter increments.
- On the BIN_W-th shift edge (E+BIN_W):
  - bin_out <= shifted bin_part; rdy <= 1; busy <= 0; state -> IDLE.
  - rdy is visible for exactly the one cycle after E+BIN_W. Default latency: 14 edges.
  - At that edge bcd_part is all zeros for every legal input; the bench checks this by assertion.
- start while busy: ignored, with no queuing and no effect on bin_out or err.
- start in the cycle rdy is high (state is IDLE): accepted normally. Back-to-back conversions therefore have throughput BIN_W+1 cycles.
- bcd_in is sampled only at the accepting edge; later changes do not affect the result.
- rdy, busy, bin_out and err are all registered; there are no combinational paths from inputs to outputs.
- Arithmetic: unsigned only. Maximum output is 10^DIGITS-1 (9999 = 14'h270F); overflow is impossible by the parameter rule.

Decomposition:
- Shared package calc_pkg:
  - state encoding constants IDLE=0, SHIFT=1;
  - BCD_MAX_DIGIT=9;
  - BCD_ADJ_THRESH=8;
  - BCD_ADJ_SUB=3.
- Sub-module bcd_digit_adj (combinational, 4-bit): out = (in >= 8) ? in-3 : in.
  - Instantiated DIGITS times via generate in the shift path.
  - The same package constants drive the >9 validity check.

Test Plan:
- Reset, then start with bcd_in=16'h0000 -> rdy pulses 14 cycles after the accepting edge; bin_out=0; err=0; busy high for exactly 14 cycles.
- bcd_in=16'h9999 -> bin_out=14'h270F (9999); rdy high for one cycle only; bcd_part zero at completion.
- bcd_in=16'h0128 -> bin_out=128; then immediately start with 16'h0042 in the rdy cycle -> accepted; bin_out=42 after another 14 edges.
- bcd_in=16'h12A4 -> rdy one cycle after the accepting edge, err=1, bin_out=0, busy never asserted. Then a valid 16'h0007 clears err and yields 7.
- Start 16'h0500; pulse start with 16'h0001 at cycle 5 of SHIFT -> ignored; result is 500; no extra rdy follows.
- Start 16'h3141; assert rst asynchronously mid-cycle at shift 7 -> all outputs 0 immediately, no rdy; after release a new start with 16'h0010 yields 10.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: converter state encoding, BCD digit constants
// and a constant helper used for parameter legality checks.
package calc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_SUB    = 4'd3;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of reverse double-dabble: digits that reach 8
// after a right shift had a borrowed 10, which must become 5 (subtract 3).
module bcd_digit_adj
  import calc_pkg::*;
(
  input  logic [3:0] raw,
  output logic [3:0] adj
);

  assign adj = (raw >= BCD_ADJ_THRESH) ? raw - BCD_ADJ_SUB : raw;

endmodule

// File: rtl/bcd_val.sv
// Sequential packed-BCD to binary converter (reverse double-dabble), one shift
// per clock, with start/rdy handshake and invalid-digit flagging.
module bcd_val
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  rdy,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);

  if ((64'd1 << BIN_W) < pow10(DIGITS)) begin : g_bad_width
    $error("bcd_val: BIN_W too small to hold 10**DIGITS-1");
  end

  state_t            state_q, state_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_out_q, bin_out_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [BcdW-1:0]   bcd_shifted;
  logic [BcdW-1:0]   bcd_adjusted;
  logic [BIN_W-1:0]  bin_shifted;
  logic              bad_digit;

  // Whole work register {bcd, bin} shifts right as one.
  assign bcd_shifted = {1'b0, bcd_q[BcdW-1:1]};
  assign bin_shifted = {bcd_q[0], bin_q[BIN_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .raw (bcd_shifted[4*g +: 4]),
      .adj (bcd_adjusted[4*g +: 4])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_in[4*i +: 4] > BCD_MAX_DIGIT) begin
        bad_digit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    rdy_d     = 1'b0;
    busy_d    = busy_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (bad_digit) begin
            err_d     = 1'b1;
            bin_out_d = '0;
            rdy_d     = 1'b1;
          end else begin
            bcd_d   = bcd_in;
            bin_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        bcd_d = bcd_adjusted;
        bin_d = bin_shifted;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(BIN_W - 1)) begin
          bin_out_d = bin_shifted;
          rdy_d     = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign bin_out = bin_out_q;
  assign rdy     = rdy_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_val.sv
// Scoreboard bench for bcd_val: a driver queues expected results, a negedge
// monitor checks value, err, completion cycle and busy duration on each rdy.
module tb_bcd_val;

  localparam int unsigned Lat = 14;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [13:0] bin_out;
  logic        rdy, busy, err;

  typedef struct {
    logic [13:0] bin;
    logic        err;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned busy_run = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  bcd_val #(.DIGITS(4), .BIN_W(14)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .rdy     (rdy),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: everything is sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        check("busy_len", busy_run, Lat);
        busy_run = 0;
      end
      if (rdy) begin
        if (sb.size() == 0) begin
          check("unexpected_rdy", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("bin_out", 32'(bin_out), 32'(e.bin));
          check("err", 32'(err), 32'(e.err));
          check("rdy_cycle", cyc, e.cyc);
          check("busy_at_rdy", 32'(busy), 32'd0);
          if (!e.err) check("bcd_part_zero", 32'(dut.bcd_q), 32'd0);
        end
      end
    end
  end

  // Called right after a falling edge; the next rising edge is the accepting one.
  task automatic issue(input logic [15:0] bcd, input logic [13:0] exp_bin,
                       input logic exp_err);
    exp_t e;
    start  = 1'b1;
    bcd_in = bcd;
    e.bin  = exp_bin;
    e.err  = exp_err;
    e.cyc  = cyc + 1 + (exp_err ? 0 : Lat);
    sb.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 16'hFFFF;  // later changes must not matter
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("completion_timeout", sb.size(), 0);
  endtask

  task automatic wait_rdy();
    for (int i = 0; i < 40 && !rdy; i++) @(negedge clk);
    check("rdy_seen", 32'(rdy), 32'd1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check("reset_bin_out", 32'(bin_out), 0);
    check("reset_rdy", 32'(rdy), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_err", 32'(err), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue(16'h0000, 14'd0, 1'b0);
    wait_done();
    @(negedge clk);
    issue(16'h9999, 14'h270F, 1'b0);
    wait_done();
    @(negedge clk);

    // Second start lands in the rdy cycle of the first.
    issue(16'h0128, 14'd128, 1'b0);
    wait_rdy();
    issue(16'h0042, 14'd42, 1'b0);
    wait_done();
    @(negedge clk);

    issue(16'h12A4, 14'd0, 1'b1);
    wait_done();
    @(negedge clk);
    issue(16'h0007, 14'd7, 1'b0);
    wait_done();
    @(negedge clk);

    // Start while busy is ignored.
    issue(16'h0500, 14'd500, 1'b0);
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bcd_in = 16'h0001;
    @(negedge clk);
    start  = 1'b0;
    wait_done();
    repeat (20) @(negedge clk);

    // Abandon a conversion with an asynchronous reset mid-cycle.
    issue(16'h3141, 14'd3141, 1'b0);
    void'(sb.pop_back());
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset_bin_out", 32'(bin_out), 0);
    check("midreset_rdy", 32'(rdy), 0);
    check("midreset_busy", 32'(busy), 0);
    check("midreset_err", 32'(err), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(16'h0010, 14'd10, 1'b0);
    wait_done();
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
